// File: rtl/middle_pe_row32_pkg.sv
// -----------------------------------------------------------------------------
// middle_pe_row32_pkg
// Shared constants for the middle-row PE array and the lane-to-filter-row map.
// Ports: none (package).
// -----------------------------------------------------------------------------
package middle_pe_row32_pkg;

  localparam int NUM_PE   = 32;
  localparam int IFMAP_W  = 8;
  localparam int WGT_W    = 4;
  localparam int TAPS     = 3;
  localparam int PSUM_W   = IFMAP_W + WGT_W + 2;
  localparam int NUM_ROWS = 3;

  // Filter rows are dealt out round-robin starting from row 2 at lane 0.
  function automatic int unsigned lane_row(input int unsigned lane);
    return 32'd2 - (lane % 32'd3);
  endfunction

endpackage

// File: rtl/middle_pe_row32_pe_conv3.sv
// -----------------------------------------------------------------------------
// pe_conv3
// One PE lane: 3-deep activation window, three unsigned multipliers and an
// adder tree feeding a registered partial sum.
// Ports:
//   clk_i   - clock, all state on posedge
//   rst_i   - asynchronous active-high reset
//   en_i    - shift window and update psum
//   x_i     - incoming activation byte
//   w_i     - filter row {wA(oldest), wB(middle), wC(newest)}
//   psum_o  - registered partial sum
// -----------------------------------------------------------------------------
module pe_conv3
  import middle_pe_row32_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [IFMAP_W-1:0]      x_i,
  input  logic [TAPS*WGT_W-1:0]   w_i,
  output logic [PSUM_W-1:0]       psum_o
);

  localparam int PROD_W = IFMAP_W + WGT_W;

  logic [IFMAP_W-1:0] x_old_q, x_mid_q, x_new_q;
  logic [PSUM_W-1:0]  psum_q, psum_d;
  logic [WGT_W-1:0]   w_a, w_b, w_c;
  logic [PROD_W-1:0]  p_a, p_b, p_c;

  assign w_a = w_i[3*WGT_W-1 -: WGT_W];
  assign w_b = w_i[2*WGT_W-1 -: WGT_W];
  assign w_c = w_i[WGT_W-1   -: WGT_W];

  // Products use the window as it stands before the edge; the byte arriving
  // this cycle only joins the sum on the following enabled edge.
  always_comb begin
    p_a    = PROD_W'(x_old_q) * PROD_W'(w_a);
    p_b    = PROD_W'(x_mid_q) * PROD_W'(w_b);
    p_c    = PROD_W'(x_new_q) * PROD_W'(w_c);
    // Max 3*255*15 = 11475 fits in 14 bits, so no saturation is needed.
    psum_d = PSUM_W'(p_a) + PSUM_W'(p_b) + PSUM_W'(p_c);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_old_q <= '0;
      x_mid_q <= '0;
      x_new_q <= '0;
      psum_q  <= '0;
    end else if (en_i) begin
      x_old_q <= x_mid_q;
      x_mid_q <= x_new_q;
      x_new_q <= x_i;
      psum_q  <= psum_d;
    end
  end

  assign psum_o = psum_q;

endmodule

// File: rtl/middle_pe_row32.sv
// -----------------------------------------------------------------------------
// middle_pe_row32
// Middle-row array of 32 independent 3-tap convolution PEs. Each lane takes
// one activation byte per enabled cycle; three shared filter rows are mapped
// round-robin onto the lanes (lane j uses row 2 - j mod 3).
// Ports:
//   clk             - clock
//   rst             - asynchronous active-high reset
//   en              - global enable
//   Ifmap_shift_in  - 32 activation bytes, lane 0 in the MSB byte
//   Filtr_in_2/1/0  - filter rows, each {wA, wB, wC}
//   Psum_out        - 32 x 14-bit psums, lane 0 in the MSBs
// -----------------------------------------------------------------------------
module middle_pe_row32
  import middle_pe_row32_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_PE*IFMAP_W-1:0]     Ifmap_shift_in,
  input  logic [TAPS*WGT_W-1:0]         Filtr_in_2,
  input  logic [TAPS*WGT_W-1:0]         Filtr_in_1,
  input  logic [TAPS*WGT_W-1:0]         Filtr_in_0,
  output logic [NUM_PE*PSUM_W-1:0]      Psum_out
);

  logic [TAPS*WGT_W-1:0] filt_row [NUM_ROWS];

  assign filt_row[0] = Filtr_in_0;
  assign filt_row[1] = Filtr_in_1;
  assign filt_row[2] = Filtr_in_2;

  for (genvar j = 0; j < NUM_PE; j++) begin : g_pe
    localparam logic [1:0] ROW = 2'(lane_row(j));

    // Lane 0 lives in the most significant slice of both buses.
    pe_conv3 u_pe (
      .clk_i  (clk),
      .rst_i  (rst),
      .en_i   (en),
      .x_i    (Ifmap_shift_in[(NUM_PE-1-j)*IFMAP_W +: IFMAP_W]),
      .w_i    (filt_row[ROW]),
      .psum_o (Psum_out[(NUM_PE-1-j)*PSUM_W +: PSUM_W])
    );
  end

endmodule

// File: tb/tb_middle_pe_row32.sv
module tb_middle_pe_row32;

  localparam int NP   = 32;
  localparam int MAXH = 2048;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic [255:0] ifmap = '0;
  logic [11:0]  f2 = '0, f1 = '0, f0 = '0;
  logic [447:0] psum;

  int n_cmp = 0;
  int n_bad = 0;

  logic [447:0] exp_q[$];

  // Reference model: the byte stream each lane has captured since reset,
  // and the last psum it should be presenting.
  int hist [NP][MAXH];
  int n_cap = 0;
  int last [NP];

  middle_pe_row32 dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .Ifmap_shift_in (ifmap),
    .Filtr_in_2     (f2),
    .Filtr_in_1     (f1),
    .Filtr_in_0     (f0),
    .Psum_out       (psum)
  );

  always #5 clk = ~clk;

  function automatic int lane_psum(input logic [447:0] v, input int j);
    return int'(v[(NP-1-j)*14 +: 14]);
  endfunction

  function automatic int sample(input int j, input int k);
    return (k < 1) ? 0 : hist[j][k];
  endfunction

  function automatic logic [11:0] wsel(input int j, input logic [11:0] w2,
                                       input logic [11:0] w1, input logic [11:0] w0);
    int r;
    r = 2 - (j % 3);
    case (r)
      2:       return w2;
      1:       return w1;
      default: return w0;
    endcase
  endfunction

  function automatic logic [447:0] model_vec();
    logic [447:0] v;
    v = '0;
    for (int j = 0; j < NP; j++) v[(NP-1-j)*14 +: 14] = 14'(last[j]);
    return v;
  endfunction

  task automatic model_reset();
    n_cap = 0;
    for (int j = 0; j < NP; j++) last[j] = 0;
  endtask

  // 3-tap correlation over the captured stream: with n bytes seen, the edge
  // computes wA*s[n-2] + wB*s[n-1] + wC*s[n], then appends the new byte.
  task automatic model_edge(input logic r, input logic e, input logic [255:0] b,
                            input logic [11:0] w2, input logic [11:0] w1,
                            input logic [11:0] w0);
    logic [11:0] w;
    if (r) begin
      model_reset();
    end else if (e) begin
      for (int j = 0; j < NP; j++) begin
        w = wsel(j, w2, w1, w0);
        last[j] = int'(w[11:8]) * sample(j, n_cap - 2)
                + int'(w[7:4])  * sample(j, n_cap - 1)
                + int'(w[3:0])  * sample(j, n_cap);
      end
      n_cap++;
      if (n_cap >= MAXH) $fatal(1, "FAIL model_hist: history overflow %0d", n_cap);
      for (int j = 0; j < NP; j++) hist[j][n_cap] = int'(b[(NP-1-j)*8 +: 8]);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [255:0] b,
                      input logic [11:0] w2, input logic [11:0] w1,
                      input logic [11:0] w0);
    @(negedge clk);
    rst = r; en = e; ifmap = b; f2 = w2; f1 = w1; f0 = w0;
    model_edge(r, e, b, w2, w1, w0);
    exp_q.push_back(model_vec());
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [255:0] rand_bytes();
    logic [255:0] b;
    for (int k = 0; k < 8; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [255:0] lanes4(input int a, input int b1,
                                         input int c, input int d);
    logic [255:0] v;
    v = '0;
    v[255:248] = 8'(a);
    v[247:240] = 8'(b1);
    v[239:232] = 8'(c);
    v[231:224] = 8'(d);
    return v;
  endfunction

  // Monitor: every posedge the array presents a fresh psum vector.
  initial begin
    logic [447:0] ev;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        n_cmp++;
        if (psum !== ev) begin
          n_bad++;
          $display("FAIL psum_vec: got %h want %h", psum, ev);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] b;
    logic [255:0] one;
    int ok;
    int mx;
    model_reset();

    // Reset held with live inputs and en high.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, rand_bytes(), 12'($urandom), 12'($urandom), 12'($urandom));
    after_edge();
    chk("reset_all_zero", (psum == '0) ? 1 : 0, 1);

    // Fill latency on lane 0: byte 2 then zeros, weights {4,3,1}.
    step(1'b0, 1'b1, lanes4(2, 0, 0, 0), 12'h431, 12'h000, 12'h000);
    after_edge();
    chk("fill_e1", lane_psum(psum, 0), 0);
    step(1'b0, 1'b1, '0, 12'h431, 12'h000, 12'h000);
    after_edge();
    chk("fill_e2", lane_psum(psum, 0), 2);
    step(1'b0, 1'b1, '0, 12'h431, 12'h000, 12'h000);
    after_edge();
    chk("fill_e3", lane_psum(psum, 0), 6);
    step(1'b0, 1'b1, '0, 12'h431, 12'h000, 12'h000);
    after_edge();
    chk("fill_e4", lane_psum(psum, 0), 8);
    step(1'b0, 1'b1, '0, 12'h431, 12'h000, 12'h000);
    after_edge();
    chk("fill_e5", lane_psum(psum, 0), 0);

    // Basic stream with an enable hold between the 4th and 5th byte.
    step(1'b1, 1'b0, '0, 12'h431, 12'h320, 12'h041);
    step(1'b0, 1'b1, lanes4(2, 3, 1, 4), 12'h431, 12'h320, 12'h041);
    step(1'b0, 1'b1, lanes4(4, 2, 3, 0), 12'h431, 12'h320, 12'h041);
    step(1'b0, 1'b1, lanes4(1, 4, 2, 1), 12'h431, 12'h320, 12'h041);
    step(1'b0, 1'b1, lanes4(0, 1, 1, 2), 12'h431, 12'h320, 12'h041);
    after_edge();
    chk("basic3_l0", lane_psum(psum, 0), 21);
    chk("basic3_l1", lane_psum(psum, 1), 13);
    chk("basic3_l2", lane_psum(psum, 2), 14);
    chk("basic3_l3", lane_psum(psum, 3), 17);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, rand_bytes(), 12'($urandom), 12'($urandom), 12'($urandom));
    after_edge();
    chk("hold_l0", lane_psum(psum, 0), 21);
    chk("hold_l1", lane_psum(psum, 1), 13);
    chk("hold_l2", lane_psum(psum, 2), 14);
    chk("hold_l3", lane_psum(psum, 3), 17);
    step(1'b0, 1'b1, '0, 12'h431, 12'h320, 12'h041);
    after_edge();
    chk("basic4_l0", lane_psum(psum, 0), 19);
    chk("basic4_l1", lane_psum(psum, 1), 14);
    chk("basic4_l2", lane_psum(psum, 2), 9);
    chk("basic4_l3", lane_psum(psum, 3), 5);

    // Max value: every byte 255, every weight 15.
    step(1'b1, 1'b0, '0, 12'hfff, 12'hfff, 12'hfff);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '1, 12'hfff, 12'hfff, 12'hfff);
    after_edge();
    mx = 0;
    for (int j = 0; j < NP; j++) if (lane_psum(psum, j) == 11475) mx++;
    chk("max_lanes_11475", mx, NP);

    // Row mapping: unit byte on every lane, distinct rows.
    step(1'b1, 1'b0, '0, 12'h123, 12'h456, 12'h789);
    for (int j = 0; j < NP; j++) one[j*8 +: 8] = 8'd1;
    step(1'b0, 1'b1, one, 12'h123, 12'h456, 12'h789);
    step(1'b0, 1'b1, '0, 12'h123, 12'h456, 12'h789);
    after_edge();
    chk("row_l29_wc", lane_psum(psum, 29), 9);
    chk("row_l30_wc", lane_psum(psum, 30), 3);
    chk("row_l31_wc", lane_psum(psum, 31), 6);
    step(1'b0, 1'b1, '0, 12'h123, 12'h456, 12'h789);
    after_edge();
    chk("row_l29_wb", lane_psum(psum, 29), 8);
    chk("row_l30_wb", lane_psum(psum, 30), 2);
    chk("row_l31_wb", lane_psum(psum, 31), 5);

    // Randomized traffic: random bytes, weights, enable and rare resets.
    step(1'b1, 1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 400; i++) begin
      b = rand_bytes();
      step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           b, 12'($urandom), 12'($urandom), 12'($urandom));
    end

    // Asynchronous reset mid-stream, between clock edges.
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, rand_bytes(), 12'($urandom), 12'($urandom), 12'($urandom));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_clear", (psum == '0) ? 1 : 0, 1);
    model_reset();
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, rand_bytes(), 12'($urandom), 12'($urandom), 12'($urandom));

    ok = 0;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) ok = 1;
    end
    chk("drain_queue", ok, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
